// File: rtl/aes_pkg.sv
// Shared AES-128 helpers and FSM encodings for the fpga_top codebase slice.
// Contents: AES FSM / UART FSM state encodings, S-box table, Rcon lookup,
// xtime / MixColumns, SubBytes, ShiftRows and the one-step key expansion.
// State byte i lives in bits [127-8i -: 8]; column c is bytes 4c..4c+3.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_SUB, ST_SHIFT, ST_MIX, ST_ARK, ST_DONE
  } aes_fsm_e;

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } uart_fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = mix_column(s[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4 of the same row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter.
// Ports: clk, rst_n (sync, active-low), data[7:0] byte to send, start (level
// request; a byte is taken on any edge where start && !busy), tx serial line
// (idle high), busy (cannot take a byte this cycle).
// busy drops during the last clock of the stop bit so that a pending byte
// begins its start bit immediately after, keeping frames back to back.
module uart_tx_8n1
  import aes_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_fsm_e        st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (st != U_IDLE) && !((st == U_STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= U_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (start && !busy) begin
      st      <= U_START;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= data;
    end else begin
      case (st)
        U_IDLE: tx <= 1'b1;
        U_START: begin
          if (bit_end) begin
            cnt <= '0;
            st  <= U_DATA;
            tx  <= shreg[0];
          end else cnt <= cnt + 1'b1;
        end
        U_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              st <= U_STOP;
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else cnt <= cnt + 1'b1;
        end
        U_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            st  <= U_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fpga_top.sv
// Fixed-block AES-128 encryptor with UART readout.
// After reset release the block PLAIN is encrypted under KEY, one state
// transformation per clock (SUB, SHIFT, MIX, ARK; the last round skips MIX),
// and the 16 ciphertext bytes are sent once over uart_tx, byte 0 first.
// Ports: clk system clock, rst_n sync active-low reset, uart_tx 8N1 output.
// Probe nets: w_plain (= PLAIN), w_cipher (0 until the last ARK).
module fpga_top
  import aes_pkg::*;
#(
  parameter int           CLKS_PER_BIT = 87,
  parameter logic [127:0] PLAIN        = 128'h3243f6a8885a308d313198a2e0370734,
  parameter logic [127:0] KEY          = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
  input  logic clk,
  input  logic rst_n,
  output logic uart_tx
);

  logic [127:0] w_plain;
  logic [127:0] w_cipher;
  aes_fsm_e     fsm;
  logic [127:0] aes_state;
  logic [127:0] round_key;
  logic [3:0]   round_cnt;
  logic [127:0] next_key;
  logic [4:0]   byte_idx;
  logic [3:0]   byte_sel;
  logic         tx_start;
  logic         tx_busy;
  logic [7:0]   tx_data;

  assign w_plain = PLAIN;

  // Next round key is loaded during SHIFT, so it is in place for ARK.
  assign next_key = key_expand(round_key, rcon(round_cnt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      aes_state <= '0;
      round_key <= '0;
      round_cnt <= '0;
      w_cipher  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: fsm <= ST_INIT;
        ST_INIT: begin
          aes_state <= w_plain ^ KEY;
          round_key <= KEY;
          round_cnt <= 4'd1;
          fsm       <= ST_SUB;
        end
        ST_SUB: begin
          aes_state <= sub_bytes(aes_state);
          fsm       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          aes_state <= shift_rows(aes_state);
          round_key <= next_key;
          fsm       <= (round_cnt == LAST_ROUND) ? ST_ARK : ST_MIX;
        end
        ST_MIX: begin
          aes_state <= mix_columns(aes_state);
          fsm       <= ST_ARK;
        end
        ST_ARK: begin
          aes_state <= aes_state ^ round_key;
          if (round_cnt == LAST_ROUND) begin
            w_cipher <= aes_state ^ round_key;
            fsm      <= ST_DONE;
          end else begin
            round_cnt <= round_cnt + 4'd1;
            fsm       <= ST_SUB;
          end
        end
        ST_DONE: fsm <= ST_DONE;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // Byte sequencer: keeps a request up until all 16 bytes were accepted.
  assign tx_start = (fsm == ST_DONE) && (byte_idx != 5'd16);
  assign byte_sel = 4'd15 - byte_idx[3:0];
  assign tx_data  = 8'(w_cipher >> {byte_sel, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) byte_idx <= '0;
    else if (tx_start && !tx_busy) byte_idx <= byte_idx + 5'd1;
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .start(tx_start),
    .tx   (uart_tx),
    .busy (tx_busy)
  );

endmodule

// File: tb/tb_fpga_top.sv
// Bench for fpga_top: AES trace, ciphertext latency, UART framing and
// reset behaviour, against a GF(2^8)-arithmetic AES model built here.
module tb_fpga_top;
  import aes_pkg::*;

  localparam int CPB = 4;
  localparam logic [127:0] PLAIN = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;

  int total = 0;
  int bad = 0;

  logic [127:0] exp_seq [42];
  logic [127:0] exp_rk1;
  logic [127:0] exp_cipher;

  fpga_top #(.CLKS_PER_BIT(CPB), .PLAIN(PLAIN), .KEY(KEY)) dut (
    .clk(clk), .rst_n(rst_n), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] msbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] v);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = msbox(gb(v, i));
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] v);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(r+4*c) -: 8] = gb(v, r + 4*((c+r)%4));
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] v);
    logic [127:0] o = '0;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(v, 4*c + r);
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] m_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
    t = {msbox(w[3][23:16]) ^ rc, msbox(w[3][15:8]), msbox(w[3][7:0]), msbox(w[3][31:24])};
    w[0] = w[0] ^ t;
    for (int j = 1; j < 4; j++) w[j] = w[j] ^ w[j-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic build_model();
    logic [127:0] s, k;
    logic [7:0] rc;
    int idx;
    exp_seq[0] = '0;
    exp_seq[1] = '0;
    s = PLAIN ^ KEY; k = KEY; rc = 8'h01; idx = 2;
    exp_seq[2] = s;
    for (int r = 1; r <= 10; r++) begin
      s = m_sub(s);   idx++; exp_seq[idx] = s;
      s = m_shift(s); idx++; exp_seq[idx] = s;
      k = m_key(k, rc);
      if (r == 1) exp_rk1 = k;
      rc = gmul(rc, 8'h02);
      if (r < 10) begin s = m_mix(s); idx++; exp_seq[idx] = s; end
      s = s ^ k;      idx++; exp_seq[idx] = s;
    end
    exp_cipher = s;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  // Captures one UART frame; sampling points are mid-bit on negedges.
  task automatic uart_get_byte(output logic [7:0] b, output logic start_ok,
                               output logic stop_ok, output int wait_cyc, output logic timeout);
    wait_cyc = 0; timeout = 1'b0; b = 8'h00; start_ok = 1'b0; stop_ok = 1'b0;
    while (uart_tx !== 1'b0 && wait_cyc < 400) begin @(negedge clk); wait_cyc++; end
    if (uart_tx !== 1'b0) begin timeout = 1'b1; return; end
    @(negedge clk); start_ok = (uart_tx === 1'b0);
    for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); b[i] = uart_tx; end
    repeat (CPB) @(negedge clk); stop_ok = (uart_tx === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n = $urandom_range(3, 8);
    @(negedge clk); rst_n = 1'b0;
    repeat (n) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
    total++; if (dut.w_cipher !== 128'h0) begin bad++; $display("FAIL rst_cipher: got %h want 0", dut.w_cipher); end
    total++; if (dut.aes_state !== 128'h0) begin bad++; $display("FAIL rst_state: got %h want 0", dut.aes_state); end
    total++; if (dut.round_cnt !== 4'd0) begin bad++; $display("FAIL rst_round: got %0d want 0", dut.round_cnt); end
    total++; if (dut.fsm !== ST_IDLE) begin bad++; $display("FAIL rst_fsm: got %0d want IDLE", dut.fsm); end
    total++; if (dut.byte_idx !== 5'd0) begin bad++; $display("FAIL rst_byte_idx: got %0d want 0", dut.byte_idx); end
    total++; if (dut.w_plain !== PLAIN) begin bad++; $display("FAIL w_plain: got %h want %h", dut.w_plain, PLAIN); end
  endtask

  task automatic test_aes_trace();
    rst_n = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++;
      if (dut.aes_state !== exp_seq[k]) begin
        bad++; $display("FAIL state@%0d: got %h want %h", k, dut.aes_state, exp_seq[k]);
      end
      total++;
      if (dut.w_cipher !== ((k == 41) ? exp_cipher : 128'h0)) begin
        bad++; $display("FAIL cipher@%0d: got %h want %h", k, dut.w_cipher, (k == 41) ? exp_cipher : 128'h0);
      end
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_idle@%0d: got %b want 1", k, uart_tx); end
      if (k == 6) begin
        total++;
        if (dut.round_key !== exp_rk1) begin
          bad++; $display("FAIL round1_key: got %h want %h", dut.round_key, exp_rk1);
        end
      end
    end
  endtask

  task automatic test_uart();
    logic [7:0] b;
    logic s_ok, p_ok, to;
    int w, lows;
    for (int i = 0; i < 16; i++) begin
      uart_get_byte(b, s_ok, p_ok, w, to);
      total++;
      if (to) begin bad++; $display("FAIL uart_timeout[%0d]: got none want frame", i); break; end
      total++; if (b !== gb(exp_cipher, i)) begin bad++; $display("FAIL uart_byte[%0d]: got %h want %h", i, b, gb(exp_cipher, i)); end
      total++; if (!s_ok || !p_ok) begin bad++; $display("FAIL uart_frame[%0d]: got start_ok=%b stop_ok=%b want 1 1", i, s_ok, p_ok); end
      total++; if (w != ((i == 0) ? 1 : CPB - 1)) begin bad++; $display("FAIL uart_gap[%0d]: got %0d want %0d", i, w, (i == 0) ? 1 : CPB - 1); end
    end
    lows = 0;
    repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("FAIL uart_after: got %0d low samples want 0", lows); end
  endtask

  task automatic test_reset_mid_enc();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (uart_tx !== 1'b1 || dut.aes_state !== 128'h0 || dut.w_cipher !== 128'h0) begin
        bad++; $display("FAIL enc_rst@%0d: got tx=%b state=%h want tx=1 state=0", i, uart_tx, dut.aes_state);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      total++;
      if (dut.aes_state !== exp_seq[k]) begin
        bad++; $display("FAIL enc_rerun_state@%0d: got %h want %h", k, dut.aes_state, exp_seq[k]);
      end
    end
    total++; if (dut.w_cipher !== exp_cipher) begin bad++; $display("FAIL enc_rerun_cipher: got %h want %h", dut.w_cipher, exp_cipher); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b, b5;
    logic s_ok, p_ok, to;
    int w, k, cyc, hold;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uart_get_byte(b, s_ok, p_ok, w, to);
      total++;
      if (to || b !== gb(exp_cipher, i)) begin bad++; $display("FAIL tx_pre[%0d]: got %h want %h", i, b, gb(exp_cipher, i)); end
    end
    cyc = 0;
    while (uart_tx !== 1'b0 && cyc < 400) begin @(negedge clk); cyc++; end
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL tx_byte5_start: got %b want 0", uart_tx); end
    b5 = gb(exp_cipher, 5);
    do k = $urandom_range(0, 39); while (frame_bit(b5, k / CPB) != 1'b0);
    repeat (k) @(negedge clk);
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL tx_byte5_bit@%0d: got %b want 0", k, uart_tx); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_rst_high: got %b want 1", uart_tx); end
    hold = $urandom_range(2, 6);
    repeat (hold) @(negedge clk);
    total++; if (uart_tx !== 1'b1 || dut.byte_idx !== 5'd0) begin bad++; $display("FAIL tx_rst_hold: got tx=%b idx=%0d want 1 0", uart_tx, dut.byte_idx); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_get_byte(b, s_ok, p_ok, w, to);
      total++;
      if (to) begin bad++; $display("FAIL tx_resend_timeout[%0d]: got none want frame", i); break; end
      total++; if (b !== gb(exp_cipher, i)) begin bad++; $display("FAIL tx_resend[%0d]: got %h want %h", i, b, gb(exp_cipher, i)); end
      total++; if (!s_ok || !p_ok || w != ((i == 0) ? 42 : CPB - 1)) begin
        bad++; $display("FAIL tx_resend_frame[%0d]: got s=%b p=%b wait=%0d want 1 1 %0d", i, s_ok, p_ok, w, (i == 0) ? 42 : CPB - 1);
      end
    end
  endtask

  task automatic test_random_resets();
    logic [7:0] b;
    logic s_ok, p_ok, to;
    int w, cut, dur;
    for (int it = 0; it < 4; it++) begin
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cut = $urandom_range(1, 41 + 16 * 10 * CPB);
      repeat (cut) @(negedge clk);
      rst_n = 1'b0;
      dur = $urandom_range(1, 12);
      for (int i = 0; i < dur; i++) begin
        @(negedge clk);
        total++;
        if (uart_tx !== 1'b1 || dut.w_cipher !== 128'h0) begin
          bad++; $display("FAIL rnd_rst[%0d]@%0d: got tx=%b cipher=%h want 1 0", it, i, uart_tx, dut.w_cipher);
        end
      end
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (dut.w_cipher !== 128'h0) begin bad++; $display("FAIL rnd_early[%0d]: got %h want 0", it, dut.w_cipher); end
      @(negedge clk);
      total++; if (dut.w_cipher !== exp_cipher) begin bad++; $display("FAIL rnd_cipher[%0d]: got %h want %h", it, dut.w_cipher, exp_cipher); end
      uart_get_byte(b, s_ok, p_ok, w, to);
      total++;
      if (to || b !== gb(exp_cipher, 0) || !s_ok || !p_ok || w != 1) begin
        bad++; $display("FAIL rnd_byte0[%0d]: got %h wait=%0d want %h wait=1", it, b, w, gb(exp_cipher, 0));
      end
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_aes_trace();
    test_uart();
    test_reset_mid_enc();
    test_reset_mid_tx();
    test_random_resets();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_top.md
FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clocks per UART bit (10 MHz / 115200 baud).
REQ-002 SHALL have parameter PLAIN, default 128'h3243f6a8885a308d313198a2e0370734, meaning the fixed plaintext block.
REQ-003 SHALL have parameter KEY, default 128'h2b7e151628aed2a6abf7158809cf4f3c, meaning the fixed AES-128 key.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port uart_tx, output, 1 bit: serial output, 8N1, idle high.
REQ-007 SHALL expose internal nets w_plain[127:0] (=PLAIN) and w_cipher[127:0] (0 until encryption completes, then the ciphertext) for bench probing.

Function
REQ-008 SHALL, after reset release, encrypt PLAIN under KEY with AES-128 (FIPS-197), byte 0 = bits [127:120].
REQ-009 SHALL run the AES core as an FSM: IDLE, INIT, SUB, SHIFT, MIX, ARK, DONE.
REQ-010 SHALL leave IDLE on the first clock with rst_n high and go to INIT.
REQ-011 SHALL, in INIT, load state = PLAIN xor KEY and load round key = KEY, round = 1.
REQ-012 SHALL sequence each round as SUB, SHIFT, MIX, ARK with one state update per clock; round 10 skips MIX.
REQ-013 SHALL compute the next round key (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) during MIX/SHIFT so that it is valid for ARK.
REQ-014 SHALL, after ARK of round 10, latch state into w_cipher and enter DONE; total latency is 41 clocks from reset release to w_cipher valid.
REQ-015 SHALL implement the S-box either as a 256-entry table or combinationally (GF(2^8) inverse + affine); 16 state and 4 key S-box instances are allowed.
REQ-016 SHALL, on entering DONE, transmit the 16 cipher bytes over uart_tx, byte 0 first.
REQ-017 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each CLKS_PER_BIT clocks long, back to back.
REQ-018 SHALL hold uart_tx high after the last stop bit and send nothing further until the next reset.
REQ-019 SHALL restart from IDLE if reset is asserted mid-encryption or mid-transmission; a partial UART frame is abandoned and the line driven high.

Reset
REQ-020 SHALL, while rst_n is low at a clock edge, set FSM = IDLE, state = 0, round = 0, w_cipher = 0, UART FSM idle, byte index = 0, uart_tx = 1.
REQ-021 SHALL take no action on an asynchronous rst_n edge; reset is sampled on clk only.

Structure
REQ-022 SHALL place the S-box function, the Rcon table, the xtime/MixColumns function and the FSM state encodings in a shared package aes_pkg.
REQ-023 SHALL contain exactly one sub-module, uart_tx_8n1 (inputs clk, rst_n, data[7:0], start; outputs tx, busy); the AES datapath is inline in fpga_top.

Verification
REQ-024 SHALL verify the AES intermediate values: reset, release -> after INIT state = 193de3bea0f4e22b9ac68d2ae9f84808; after SUB d42711aee0bf98f1b8b45de51e415230; after SHIFT d4bf5d30e0b452aeb84111f11e2798e5; after MIX 046681e5e0cb199a48f8d37a2806264c.
REQ-025 SHALL verify the round-1 key and result: round-1 key = a0fafe17 88542cb1 23a33939 2a6c7605, and the state after round-1 ARK = a49c7ff2689f352b6b5bea43026a5049.
REQ-026 SHALL verify the final ciphertext: w_cipher = 3925841d02dc09fbdc118597196a0b32 exactly 41 clocks after release, and 0 before that.
REQ-027 SHALL verify the UART output with CLKS_PER_BIT = 4: decode uart_tx into 16 bytes 39 25 84 1d ... 0b 32, framing correct, and the line stays high afterwards.
REQ-028 SHALL verify reset during encryption: assert rst_n low in cycle 20 for 20 clocks, then release -> identical state sequence and ciphertext, and uart_tx high throughout reset.
REQ-029 SHALL verify reset during transmission: assert reset mid-byte-5 -> uart_tx returns high next clock, and after release the full 16-byte frame is resent from byte 0.
